// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-style control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes opcode/funct (held in the external IR) into datapath control strobes.
module multicycle_control_unit #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int ALUCTRL_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 iord,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic [1:0]           pc_src,
    output logic                 pc_en,
    output logic                 illegal_op,
    output logic [3:0]           state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state_q;
    state_t     state_d;
    logic       ready_s;
    logic [2:0] alu_ctrl_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic       pc_en_s;
    logic       illegal_op_s;

    assign ready_s = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    // Next-state selection; unused codes fall back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = ready_s ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_RTYPE:       state_d = S_EXECUTE;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:        state_d = S_ADDIEX;
                    OP_J:           state_d = S_JUMP;
                    default:        state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                case (op)
                    OP_LW:   state_d = S_MEMREAD;
                    OP_SW:   state_d = S_MEMWRITE;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMREAD:  state_d = ready_s ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = ready_s ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEX:   state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-state control decode; strobes are gated by ready/zero within the state.
    always_comb begin
        mem_req      = 1'b0;
        iord         = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_ctrl_s   = ALU_ADD;
        pc_src       = 2'b00;
        pc_en_s      = 1'b0;
        illegal_op_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b01;
                ir_write_s = ready_s;
                pc_en_s    = ready_s;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: illegal_op_s = 1'b0;
                    default: illegal_op_s = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_write_s = 1'b1;
                mem_to_reg  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req     = 1'b1;
                iord        = 1'b1;
                mem_write_s = ready_s;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'b100000: alu_ctrl_s = ALU_ADD;
                    6'b100010: alu_ctrl_s = ALU_SUB;
                    6'b100100: alu_ctrl_s = ALU_AND;
                    6'b100101: alu_ctrl_s = ALU_OR;
                    6'b101010: alu_ctrl_s = ALU_SLT;
                    default: begin
                        alu_ctrl_s   = ALU_ADD;
                        illegal_op_s = 1'b1;
                    end
                endcase
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                reg_dst     = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_ctrl_s = ALU_SUB;
                pc_src     = 2'b01;
                pc_en_s    = (op == OP_BNE) ? ~zero : zero;
            end
            S_ADDIWB: begin
                reg_write_s = 1'b1;
            end
            S_JUMP: begin
                pc_src  = 2'b10;
                pc_en_s = 1'b1;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    // Architectural side effects are suppressed while reset is asserted.
    assign mem_write   = mem_write_s  & rst_n;
    assign ir_write    = ir_write_s   & rst_n;
    assign reg_write   = reg_write_s  & rst_n;
    assign pc_en       = pc_en_s      & rst_n;
    assign illegal_op  = illegal_op_s & rst_n;
    assign alu_control = ALUCTRL_W'(alu_ctrl_s);
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: directed per-cycle vectors push expected outputs, a negedge monitor pops and compares.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       illegal_op;
    } out_t;

    typedef struct {
        bit    sel;
        out_t  e;
        string name;
    } item_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic       clk = 1'b0;
    logic       rst0_n, rst1_n, mr0, zero;
    logic [5:0] op, funct;

    logic       mem_req0, iord0, mem_write0, ir_write0, reg_dst0, mem_to_reg0, reg_write0, alu_src_a0, pc_en0, ill0;
    logic [1:0] alu_src_b0, pc_src0;
    logic [2:0] alu_control0;
    logic [3:0] st0;
    logic       mem_req1, iord1, mem_write1, ir_write1, reg_dst1, mem_to_reg1, reg_write1, alu_src_a1, pc_en1, ill1;
    logic [1:0] alu_src_b1, pc_src1;
    logic [2:0] alu_control1;
    logic [3:0] st1;

    out_t  act0, act1;
    item_t sbq[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.MEM_HANDSHAKE(1), .ALUCTRL_W(3)) dut0 (
        .clk(clk), .rst_n(rst0_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mr0),
        .mem_req(mem_req0), .iord(iord0), .mem_write(mem_write0), .ir_write(ir_write0),
        .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0), .reg_write(reg_write0),
        .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .alu_control(alu_control0),
        .pc_src(pc_src0), .pc_en(pc_en0), .illegal_op(ill0), .state(st0)
    );

    multicycle_control_unit #(.MEM_HANDSHAKE(0), .ALUCTRL_W(3)) dut1 (
        .clk(clk), .rst_n(rst1_n), .op(op), .funct(funct), .zero(zero), .mem_ready(1'b0),
        .mem_req(mem_req1), .iord(iord1), .mem_write(mem_write1), .ir_write(ir_write1),
        .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1), .reg_write(reg_write1),
        .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .alu_control(alu_control1),
        .pc_src(pc_src1), .pc_en(pc_en1), .illegal_op(ill1), .state(st1)
    );

    assign act0 = {st0, mem_req0, iord0, mem_write0, ir_write0, reg_dst0, mem_to_reg0, reg_write0,
                   alu_src_a0, alu_src_b0, alu_control0, pc_src0, pc_en0, ill0};
    assign act1 = {st1, mem_req1, iord1, mem_write1, ir_write1, reg_dst1, mem_to_reg1, reg_write1,
                   alu_src_a1, alu_src_b1, alu_control1, pc_src1, pc_en1, ill1};

    // Hand-tabulated per-state outputs with every ready/zero-gated strobe low.
    function automatic out_t base(input logic [3:0] s);
        out_t o;
        o = '0;
        o.st = s;
        o.alu_control = 3'b010;
        case (s)
            4'd0:  begin o.mem_req = 1'b1; o.alu_src_b = 2'b01; end
            4'd1:  o.alu_src_b = 2'b11;
            4'd2:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            4'd3:  begin o.mem_req = 1'b1; o.iord = 1'b1; end
            4'd4:  begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
            4'd5:  begin o.mem_req = 1'b1; o.iord = 1'b1; end
            4'd6:  o.alu_src_a = 1'b1;
            4'd7:  begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
            4'd8:  begin o.alu_src_a = 1'b1; o.alu_control = 3'b110; o.pc_src = 2'b01; end
            4'd9:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            4'd10: o.reg_write = 1'b1;
            4'd11: begin o.pc_src = 2'b10; o.pc_en = 1'b1; end
            default: o.st = s;
        endcase
        return o;
    endfunction

    function automatic out_t fe(input logic rdy);
        out_t o;
        o = base(4'd0);
        o.ir_write = rdy;
        o.pc_en = rdy;
        return o;
    endfunction

    task automatic step(input bit sel, input logic rst, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input logic rdy, input out_t e, input string nm);
        item_t it;
        @(posedge clk);
        #1;
        op = o;
        funct = f;
        zero = z;
        if (sel) begin
            rst1_n = rst;
        end else begin
            rst0_n = rst;
            mr0 = rdy;
        end
        it.sel = sel;
        it.e = e;
        it.name = nm;
        sbq.push_back(it);
    endtask

    task automatic run_rtype(input logic [5:0] f, input logic [2:0] alu, input logic ill, input string nm);
        out_t e;
        step(1'b0, 1'b1, OP_R, f, 1'b0, 1'b1, fe(1'b1), {nm, "_fetch"});
        step(1'b0, 1'b1, OP_R, f, 1'b0, 1'b1, base(4'd1), {nm, "_decode"});
        e = base(4'd6);
        e.alu_control = alu;
        e.illegal_op = ill;
        step(1'b0, 1'b1, OP_R, f, 1'b0, 1'b1, e, {nm, "_execute"});
        step(1'b0, 1'b1, OP_R, f, 1'b0, 1'b1, base(4'd7), {nm, "_aluwb"});
    endtask

    task automatic run_branch(input logic [5:0] o, input logic z, input logic take, input string nm);
        out_t e;
        step(1'b0, 1'b1, o, 6'd0, z, 1'b1, fe(1'b1), {nm, "_fetch"});
        step(1'b0, 1'b1, o, 6'd0, z, 1'b1, base(4'd1), {nm, "_decode"});
        e = base(4'd8);
        e.pc_en = take;
        step(1'b0, 1'b1, o, 6'd0, z, 1'b1, e, {nm, "_branch"});
    endtask

    // Monitor: compares the popped expectation against the selected DUT mid-cycle.
    initial begin
        item_t it;
        out_t  a;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                it = sbq.pop_front();
                a = it.sel ? act1 : act0;
                n_cmp++;
                if (a !== it.e) begin
                    n_bad++;
                    $display("FAIL %s: got state=%0d outputs=%h, expected state=%0d outputs=%h",
                             it.name, a.st, a, it.e.st, it.e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        out_t e;
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        mr0 = 1'b0;
        zero = 1'b0;
        op = 6'd0;
        funct = 6'd0;
        repeat (3) @(posedge clk);

        step(1'b0, 1'b0, OP_R, 6'd0, 1'b0, 1'b1, fe(1'b0), "reset_hold");

        run_rtype(6'b100000, 3'b010, 1'b0, "add");
        run_rtype(6'b100010, 3'b110, 1'b0, "sub");
        run_rtype(6'b100100, 3'b000, 1'b0, "and");
        run_rtype(6'b100101, 3'b001, 1'b0, "or");
        run_rtype(6'b101010, 3'b111, 1'b0, "slt");
        run_rtype(6'b111111, 3'b010, 1'b1, "badfunct");

        // lw with two wait cycles on each memory access
        step(1'b0, 1'b1, OP_LW, 6'd0, 1'b0, 1'b0, fe(1'b0), "lw_fetch_w1");
        step(1'b0, 1'b1, OP_LW, 6'd0, 1'b0, 1'b0, fe(1'b0), "lw_fetch_w2");
        step(1'b0, 1'b1, OP_LW, 6'd0, 1'b0, 1'b1, fe(1'b1), "lw_fetch_rdy");
        step(1'b0, 1'b1, OP_LW, 6'd0, 1'b0, 1'b1, base(4'd1), "lw_decode");
        step(1'b0, 1'b1, OP_LW, 6'd0, 1'b0, 1'b1, base(4'd2), "lw_memadr");
        step(1'b0, 1'b1, OP_LW, 6'd0, 1'b0, 1'b0, base(4'd3), "lw_memread_w1");
        step(1'b0, 1'b1, OP_LW, 6'd0, 1'b0, 1'b0, base(4'd3), "lw_memread_w2");
        step(1'b0, 1'b1, OP_LW, 6'd0, 1'b0, 1'b1, base(4'd3), "lw_memread_rdy");
        step(1'b0, 1'b1, OP_LW, 6'd0, 1'b0, 1'b1, base(4'd4), "lw_memwb");

        // sw with one wait cycle
        step(1'b0, 1'b1, OP_SW, 6'd0, 1'b0, 1'b1, fe(1'b1), "sw_fetch");
        step(1'b0, 1'b1, OP_SW, 6'd0, 1'b0, 1'b1, base(4'd1), "sw_decode");
        step(1'b0, 1'b1, OP_SW, 6'd0, 1'b0, 1'b1, base(4'd2), "sw_memadr");
        step(1'b0, 1'b1, OP_SW, 6'd0, 1'b0, 1'b0, base(4'd5), "sw_memwrite_wait");
        e = base(4'd5);
        e.mem_write = 1'b1;
        step(1'b0, 1'b1, OP_SW, 6'd0, 1'b0, 1'b1, e, "sw_memwrite_rdy");

        run_branch(OP_BEQ, 1'b1, 1'b1, "beq_taken");
        run_branch(OP_BEQ, 1'b0, 1'b0, "beq_not_taken");
        run_branch(OP_BNE, 1'b0, 1'b1, "bne_taken");
        run_branch(OP_BNE, 1'b1, 1'b0, "bne_not_taken");

        step(1'b0, 1'b1, OP_ADDI, 6'd0, 1'b0, 1'b1, fe(1'b1), "addi_fetch");
        step(1'b0, 1'b1, OP_ADDI, 6'd0, 1'b0, 1'b1, base(4'd1), "addi_decode");
        step(1'b0, 1'b1, OP_ADDI, 6'd0, 1'b0, 1'b1, base(4'd9), "addi_ex");
        step(1'b0, 1'b1, OP_ADDI, 6'd0, 1'b0, 1'b1, base(4'd10), "addi_wb");

        step(1'b0, 1'b1, OP_J, 6'd0, 1'b0, 1'b1, fe(1'b1), "j_fetch");
        step(1'b0, 1'b1, OP_J, 6'd0, 1'b0, 1'b1, base(4'd1), "j_decode");
        step(1'b0, 1'b1, OP_J, 6'd0, 1'b0, 1'b1, base(4'd11), "j_jump");

        // undecoded opcode: one illegal pulse in DECODE, then straight back to FETCH
        step(1'b0, 1'b1, 6'b111111, 6'd0, 1'b0, 1'b1, fe(1'b1), "ill_fetch");
        e = base(4'd1);
        e.illegal_op = 1'b1;
        step(1'b0, 1'b1, 6'b111111, 6'd0, 1'b0, 1'b1, e, "ill_decode");
        step(1'b0, 1'b1, 6'b111111, 6'd0, 1'b0, 1'b1, fe(1'b1), "ill_refetch");

        // reset asserted while MEMWRITE is waiting on memory
        step(1'b0, 1'b1, OP_SW, 6'd0, 1'b0, 1'b1, base(4'd1), "rst_sw_decode");
        step(1'b0, 1'b1, OP_SW, 6'd0, 1'b0, 1'b1, base(4'd2), "rst_sw_memadr");
        step(1'b0, 1'b1, OP_SW, 6'd0, 1'b0, 1'b0, base(4'd5), "rst_sw_wait");
        step(1'b0, 1'b0, OP_SW, 6'd0, 1'b0, 1'b1, base(4'd5), "rst_cycle1_nowrite");
        step(1'b0, 1'b0, OP_SW, 6'd0, 1'b0, 1'b1, fe(1'b0), "rst_cycle2_fetch");
        step(1'b0, 1'b1, OP_SW, 6'd0, 1'b0, 1'b1, fe(1'b1), "rst_release_fetch");

        // no-handshake build: mem_ready tied low must not stall
        step(1'b1, 1'b1, OP_SW, 6'd0, 1'b0, 1'b0, fe(1'b1), "h0_fetch");
        step(1'b1, 1'b1, OP_SW, 6'd0, 1'b0, 1'b0, base(4'd1), "h0_decode");
        step(1'b1, 1'b1, OP_SW, 6'd0, 1'b0, 1'b0, base(4'd2), "h0_memadr");
        e = base(4'd5);
        e.mem_write = 1'b1;
        step(1'b1, 1'b1, OP_SW, 6'd0, 1'b0, 1'b0, e, "h0_memwrite");
        step(1'b1, 1'b1, OP_SW, 6'd0, 1'b0, 1'b0, fe(1'b1), "h0_refetch");

        repeat (2) @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Clock `clk`, rising-edge; reset `rst_n` synchronous, active-low; single clock domain.
REQ-002 Parameter `MEM_HANDSHAKE`, default 1; 1 = memory states wait for `mem_ready`, 0 = `mem_ready` ignored and treated as 1.
REQ-003 Parameter `ALUCTRL_W`, default 3; width of `alu_control`, minimum 3, upper bits zero.
REQ-004 Port table (name, direction, width, meaning):
- `clk` -- in, 1, clock.
- `rst_n` -- in, 1, sync active-low reset.
- `op` -- in, 6, instr[31:26].
- `funct` -- in, 6, instr[5:0].
- `zero` -- in, 1, ALU zero flag.
- `mem_ready` -- in, 1, memory access complete this cycle.
- `mem_req` -- out, 1, memory access in progress.
- `iord` -- out, 1, memory address select (0 = PC, 1 = ALUOut).
- `mem_write` -- out, 1, data-memory write strobe.
- `ir_write` -- out, 1, instruction register load.
- `reg_dst` -- out, 1, write-register select (1 = rd).
- `mem_to_reg` -- out, 1, writeback select (1 = memory data).
- `reg_write` -- out, 1, register file write enable.
- `alu_src_a` -- out, 1, ALU A select (0 = PC, 1 = rs).
- `alu_src_b` -- out, 2, ALU B select (00 = rt, 01 = const 4, 10 = SignImm, 11 = SignImm<<2).
- `alu_control` -- out, ALUCTRL_W, ALU function.
- `pc_src` -- out, 2, next-PC select (00 = ALU result, 01 = ALUOut, 10 = jump target).
- `pc_en` -- out, 1, PC register load.
- `illegal_op` -- out, 1, one-cycle pulse on undecoded opcode.
- `state` -- out, 4, current state (debug).

Function
REQ-005 States and encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-006 Opcode encodings: R-type=000000, lw=100011, sw=101011, beq=000100, bne=000101, addi=001000, j=000010.
REQ-007 Transitions:
- FETCH->DECODE when the memory is ready, else stay in FETCH.
- DECODE branches on opcode: lw/sw->MEMADR; R->EXECUTE; beq/bne->BRANCH; addi->ADDIEX; j->JUMP; other->FETCH.
- MEMADR->MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD->MEMWB when ready, else stay.
- MEMWRITE->FETCH when ready, else stay.
- MEMWB, ALUWB, ADDIWB, BRANCH, JUMP->FETCH.
- EXECUTE->ALUWB; ADDIEX->ADDIWB.
REQ-008 "Ready" SHALL mean `mem_ready`=1 when MEM_HANDSHAKE=1, and constant 1 when MEM_HANDSHAKE=0.
REQ-009 `mem_req`=1 exactly in FETCH, MEMREAD and MEMWRITE; `iord`=1 in MEMREAD and MEMWRITE.
REQ-010 FETCH drives `alu_src_a`=0, `alu_src_b`=01, add, `pc_src`=00; `ir_write` and `pc_en` SHALL be 1 only in the ready cycle.
REQ-011 DECODE drives `alu_src_a`=0, `alu_src_b`=11, add (branch target precompute).
REQ-012 MEMADR and ADDIEX drive `alu_src_a`=1, `alu_src_b`=10, add.
REQ-013 `mem_write`=1 in MEMWRITE only in its ready cycle; never asserted outside MEMWRITE.
REQ-014 MEMWB drives `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
REQ-015 ADDIWB drives `reg_write`=1, `mem_to_reg`=0, `reg_dst`=0.
REQ-016 ALUWB drives `reg_write`=1, `mem_to_reg`=0, `reg_dst`=1.
REQ-017 EXECUTE drives `alu_src_a`=1, `alu_src_b`=00; `alu_control` from `funct`:
- 100000 add -> 010
- 100010 sub -> 110
- 100100 and -> 000
- 100101 or -> 001
- 101010 slt -> 111
- any other funct -> 010, and `illegal_op` pulses.
REQ-018 BRANCH drives `alu_src_a`=1, `alu_src_b`=00, sub, `pc_src`=01; `pc_en` = `zero` for beq, `pc_en` = !`zero` for bne.
REQ-019 JUMP drives `pc_src`=10 and `pc_en`=1.
REQ-020 Unlisted outputs SHALL be 0 in each state; `alu_control` defaults to 010.
REQ-021 Outputs SHALL be combinational from `state`, gated only by ready (REQ-010, REQ-013) and `zero` (REQ-018); no output may depend on `op` except in DECODE and BRANCH.
REQ-022 Opcode and funct SHALL be sampled from the IR-held `op`/`funct` inputs; the block holds no instruction copy.
REQ-023 `illegal_op` SHALL pulse for one cycle in DECODE for an undecoded opcode; the FSM then returns to FETCH with no register or memory write.

Reset
REQ-024 While `rst_n`=0 at a rising edge, `state` SHALL become FETCH regardless of current state, including mid-wait in MEMREAD/MEMWRITE.
REQ-025 During reset cycles, `pc_en`, `ir_write`, `mem_write`, `reg_write` and `illegal_op` SHALL be forced to 0.
REQ-026 The first post-reset cycle SHALL present the FETCH outputs.

Verification
REQ-027 Reset: hold `rst_n`=0 for 2 cycles from state MEMWRITE -> `state`=0, `mem_write`=0 throughout; after release, FETCH outputs appear.
REQ-028 R-type add (`op`=000000, `funct`=100000, `mem_ready`=1): state sequence 0,1,6,7,0; `reg_write`=1 only in state 7 with `reg_dst`=1; `alu_control`=010 in state 6.
REQ-029 lw with 2 wait cycles per access (MEM_HANDSHAKE=1):
- sequence 0,0,0,1,2,3,3,3,4,0;
- `ir_write` high only in the third FETCH cycle;
- `reg_write`=1 in state 4 with `mem_to_reg`=1.
REQ-030 Branches:
- beq, `zero`=1 -> `pc_en`=1 in state 8.
- beq, `zero`=0 -> `pc_en`=0.
- bne, `zero`=0 -> `pc_en`=1.
- all cases: `pc_src`=01.
REQ-031 Illegal opcode 111111: sequence 0,1,0; `illegal_op`=1 for exactly the DECODE cycle; no write strobe asserted.
REQ-032 MEM_HANDSHAKE=0 build, sw with `mem_ready` tied 0: sequence 0,1,2,5,0; `mem_write`=1 for exactly one cycle.
